// File: rtl/vec_mem_ctrl.sv
// Vector load/store sequencer for the shared RAM port b: one element access per cycle.
// Latency: load done at T+vl+2, store done at T+vl+1, vl=0 done at T+1 (T = accept cycle).
// Backpressure: req_ready is high only in IDLE; request inputs are ignored while busy.
// Build option: define VMEM_STRIDE_EN to honour req_stride; otherwise the stride is fixed at 1.
module vec_mem_ctrl #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int MAX_VL = 8,
  localparam int VL_W  = $clog2(MAX_VL + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_base,
  input  logic [ADDR_W-1:0]        req_stride,
  input  logic [VL_W-1:0]          req_vl,
  input  logic [MAX_VL*DATA_W-1:0] req_wdata,
  output logic                     resp_done,
  output logic [MAX_VL*DATA_W-1:0] resp_rdata,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_din,
  input  logic [DATA_W-1:0]        ram_dout
);

  localparam int IDX_W = (MAX_VL > 1) ? $clog2(MAX_VL) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state_q,  state_d;
  logic                     we_q,     we_d;
  logic [ADDR_W-1:0]        stride_q, stride_d;
  logic [VL_W-1:0]          vl_q,     vl_d;
  logic [MAX_VL*DATA_W-1:0] wdata_q,  wdata_d;
  logic [IDX_W-1:0]         idx_q,    idx_d;
  logic                     rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic                     ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]        ram_din_q,  ram_din_d;
  logic [MAX_VL*DATA_W-1:0] rdata_q,  rdata_d;

  logic [VL_W-1:0]   req_vl_clamped;
  logic [ADDR_W-1:0] req_stride_eff;
  logic [IDX_W-1:0]  idx_nxt;
  logic              last_elem;

  assign req_vl_clamped = (req_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : req_vl;
  assign idx_nxt        = idx_q + IDX_W'(1);
  assign last_elem      = (VL_W'(idx_q) == (vl_q - VL_W'(1)));

`ifdef VMEM_STRIDE_EN
  assign req_stride_eff = req_stride;
`else
  // Unit-stride build: the stride port is kept for interface compatibility only.
  logic unused_stride;
  assign unused_stride  = ^req_stride;
  assign req_stride_eff = ADDR_W'(1);
`endif

  // Next-state logic: accept, per-element issue, and load-data capture one cycle behind issue.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    stride_d   = stride_q;
    vl_d       = vl_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    rd_vld_d   = 1'b0;
    rd_idx_d   = rd_idx_q;
    ram_we_d   = ram_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rdata_d    = rdata_q;

    // RAM read data for the element issued last cycle arrives now.
    if (rd_vld_q) begin
      rdata_d[rd_idx_q*DATA_W +: DATA_W] = ram_dout;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          stride_d   = req_stride_eff;
          vl_d       = req_vl_clamped;
          wdata_d    = req_wdata;
          idx_d      = '0;
          ram_addr_d = req_base;
          // A new load starts from a clean result so unused elements read as zero.
          if (!req_we) begin
            rdata_d = '0;
          end
          if (req_vl_clamped == '0) begin
            state_d   = S_DONE;
            ram_we_d  = 1'b0;
            ram_din_d = '0;
          end else begin
            state_d   = S_ISSUE;
            ram_we_d  = req_we;
            ram_din_d = req_we ? req_wdata[DATA_W-1:0] : '0;
          end
        end
      end
      S_ISSUE: begin
        rd_vld_d = !we_q;
        rd_idx_d = idx_q;
        if (last_elem) begin
          state_d   = we_q ? S_DONE : S_DRAIN;
          ram_we_d  = 1'b0;
          ram_din_d = '0;
        end else begin
          idx_d      = idx_nxt;
          ram_addr_d = ram_addr_q + stride_q;
          ram_din_d  = we_q ? wdata_q[idx_nxt*DATA_W +: DATA_W] : '0;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-burst abandons the remaining elements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      stride_q   <= '0;
      vl_q       <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      stride_q   <= stride_d;
      vl_q       <= vl_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      rdata_q    <= rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_done  = (state_q == S_DONE);
  assign resp_rdata = rdata_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;

endmodule

// File: tb/tb_vec_mem_ctrl.sv
// Directed bench for vec_mem_ctrl with a synchronous-read RAM model on port b.
// Table of requests with hand-computed addresses, data and done latency, then busy and reset sequences.
module tb_vec_mem_ctrl;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [16:0]  req_base;
  logic [16:0]  req_stride;
  logic [3:0]   req_vl;
  logic [255:0] req_wdata;
  logic         resp_done;
  logic [255:0] resp_rdata;
  logic         ram_we;
  logic [16:0]  ram_addr;
  logic [31:0]  ram_din;
  logic [31:0]  ram_dout;

  logic [31:0]  mem [0:131071];

  int checks;
  int errors;

  vec_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_base   (req_base),
    .req_stride (req_stride),
    .req_vl     (req_vl),
    .req_wdata  (req_wdata),
    .resp_done  (resp_done),
    .resp_rdata (resp_rdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write-enable port, read data registered one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic            we;
    logic [16:0]     base;
    logic [16:0]     stride;
    logic [3:0]      vl;
    logic [255:0]    wdata;
    int              exp_n;
    int              exp_done;
    logic [2:0][16:0] ea;
    logic [2:0][31:0] ed;
  } vec_t;

  vec_t vt [10];

  function automatic vec_t mk(input logic we, input logic [16:0] base, input logic [16:0] stride,
                              input logic [3:0] vl, input logic [255:0] wdata, input int n,
                              input int dn, input logic [2:0][16:0] ea, input logic [2:0][31:0] ed);
    vec_t v;
    v.we = we; v.base = base; v.stride = stride; v.vl = vl; v.wdata = wdata;
    v.exp_n = n; v.exp_done = dn; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  function automatic logic [255:0] pk(input logic [31:0] b);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = b + 32'(i);
    return w;
  endfunction

  function automatic logic [31:0] el(input logic [255:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int done_k;
    int ndone;
    int nwe;
    int waitc;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_base = v.base; req_stride = v.stride;
    req_vl = v.vl; req_wdata = v.wdata;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk($sformatf("v%0d ready_before_accept", idx), 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    done_k = -1; ndone = 0; nwe = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (ram_we) nwe++;
      if (k <= 3 && k <= v.exp_n) begin
        chk($sformatf("v%0d addr%0d", idx, k-1), 64'(ram_addr), 64'(v.ea[k-1]));
        chk($sformatf("v%0d din%0d", idx, k-1), 64'(ram_din),
            v.we ? 64'(el(v.wdata, k-1)) : 64'd0);
      end
      if (resp_done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
    end
    chk($sformatf("v%0d done_latency", idx), 64'(done_k), 64'(v.exp_done));
    chk($sformatf("v%0d done_pulses", idx), 64'(ndone), 64'd1);
    chk($sformatf("v%0d we_cycles", idx), 64'(nwe), v.we ? 64'(v.exp_n) : 64'd0);
    if (!v.we) begin
      for (int i = 0; i < 8; i++) begin
        if (i < 3 && i < v.exp_n)
          chk($sformatf("v%0d rdata%0d", idx, i), 64'(el(resp_rdata, i)), 64'(v.ed[i]));
        else if (i >= v.exp_n)
          chk($sformatf("v%0d rdata%0d_zero", idx, i), 64'(el(resp_rdata, i)), 64'd0);
      end
    end
  endtask

  initial begin
    int nd;
    checks = 0; errors = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_base = '0; req_stride = 17'd1;
    req_vl = '0; req_wdata = '0;
    for (int a = 0; a < 131072; a++) mem[a] = 32'hA000_0000 | 32'(a);

    vt[0] = mk(1'b0, 17'h00010, 17'd1, 4'd4, '0, 4, 6,
               {17'h12, 17'h11, 17'h10}, {32'hA000_0012, 32'hA000_0011, 32'hA000_0010});
    vt[1] = mk(1'b1, 17'h00020, 17'd1, 4'd3, pk(32'hC000_0000), 3, 4,
               {17'h22, 17'h21, 17'h20}, {32'h0, 32'h0, 32'h0});
    vt[2] = mk(1'b0, 17'h00020, 17'd1, 4'd3, '0, 3, 5,
               {17'h22, 17'h21, 17'h20}, {32'hC000_0002, 32'hC000_0001, 32'hC000_0000});
`ifdef VMEM_STRIDE_EN
    vt[3] = mk(1'b0, 17'h1FFFE, 17'd2, 4'd3, '0, 3, 5,
               {17'h00002, 17'h00000, 17'h1FFFE}, {32'hA000_0002, 32'hA000_0000, 32'hA001_FFFE});
    vt[4] = mk(1'b0, 17'h00005, 17'h1FFFF, 4'd3, '0, 3, 5,
               {17'h3, 17'h4, 17'h5}, {32'hA000_0003, 32'hA000_0004, 32'hA000_0005});
`else
    vt[3] = mk(1'b0, 17'h1FFFE, 17'd2, 4'd3, '0, 3, 5,
               {17'h00000, 17'h1FFFF, 17'h1FFFE}, {32'hA000_0000, 32'hA001_FFFF, 32'hA001_FFFE});
    vt[4] = mk(1'b0, 17'h00005, 17'h1FFFF, 4'd3, '0, 3, 5,
               {17'h7, 17'h6, 17'h5}, {32'hA000_0007, 32'hA000_0006, 32'hA000_0005});
`endif
    vt[5] = mk(1'b0, 17'h00040, 17'd1, 4'd0, '0, 0, 1, '0, '0);
    vt[6] = mk(1'b1, 17'h00030, 17'd1, 4'd15, pk(32'hD000_0000), 8, 9,
               {17'h32, 17'h31, 17'h30}, {32'h0, 32'h0, 32'h0});
    vt[7] = mk(1'b0, 17'h00030, 17'd1, 4'd15, '0, 8, 10,
               {17'h32, 17'h31, 17'h30}, {32'hD000_0002, 32'hD000_0001, 32'hD000_0000});
    vt[8] = mk(1'b1, 17'h00060, 17'd1, 4'd0, pk(32'hF000_0000), 0, 1, '0, '0);
    vt[9] = mk(1'b0, 17'h00011, 17'd1, 4'd1, '0, 1, 3,
               {17'h0, 17'h0, 17'h11}, {32'h0, 32'h0, 32'hA000_0011});

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst resp_done", 64'(resp_done), 64'd0);
    chk("rst ram_we", 64'(ram_we), 64'd0);
    chk("rst ram_addr", 64'(ram_addr), 64'd0);
    chk("rst ram_din", 64'(ram_din), 64'd0);
    chk("rst resp_rdata", 64'(resp_rdata == '0), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

    // req_valid held while busy: second request (changed to vl=0) is taken only after DONE.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_base = 17'h10; req_stride = 17'd1; req_vl = 4'd4;
    @(posedge clk);
    #1 req_base = 17'h99; req_vl = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("busy ready_k%0d", k), 64'(req_ready), 64'd0);
      if (k == 2) chk("busy addr_k2", 64'(ram_addr), 64'h11);
      if (k == 6) begin
        chk("busy done_k6", 64'(resp_done), 64'd1);
        chk("busy rdata3", 64'(el(resp_rdata, 3)), 64'hA000_0013);
      end
    end
    @(negedge clk);
    chk("busy ready_k7", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy vl0_done", 64'(resp_done), 64'd1);
    chk("busy vl0_we", 64'(ram_we), 64'd0);
    chk("busy vl0_rdata_zero", 64'(resp_rdata == '0), 64'd1);
    repeat (3) @(negedge clk);

    // Reset two cycles into an 8-element store.
    req_valid = 1'b1; req_we = 1'b1; req_base = 17'h50; req_stride = 17'd1; req_vl = 4'd8;
    req_wdata = pk(32'hE000_0000);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid we_t1", 64'(ram_we), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid we_t3", 64'(ram_we), 64'd0);
    chk("rstmid ready_t3", 64'(req_ready), 64'd1);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_done) nd++;
    end
    chk("rstmid no_done", 64'(nd), 64'd0);
    chk("rstmid mem50", 64'(mem[17'h50]), 64'hE000_0000);
    chk("rstmid mem51", 64'(mem[17'h51]), 64'hE000_0001);
    chk("rstmid mem52", 64'(mem[17'h52]), 64'hA000_0052);
    chk("rstmid mem57", 64'(mem[17'h57]), 64'hA000_0057);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
